ram_stream_dma: RTL and testbench
=================================

RAM_STREAM_DMA -- requirements
Module: ram_stream_dma

Interface
REQ-001 Parameter ADDR_W, default 16, RAM byte-address width.
REQ-002 Parameter DATA_W, default 8, RAM/stream data width.
REQ-003 Parameter LEN_W, default 16, transfer byte-count width.
REQ-004 Port clk  in  1  single clock; all state changes on rising edge.
REQ-005 Port RST  in  1  reset, asynchronous, active-high.
REQ-006 Ports cmd_valid in 1 / cmd_ready out 1; a command is accepted on a rising edge with both high.
REQ-007 Port cmd_dir  in  1  0 = LOAD (stream to RAM), 1 = DUMP (RAM to stream).
REQ-008 Ports cmd_base in ADDR_W (start address) / cmd_len in LEN_W (byte count).
REQ-009 Ports s_data in DATA_W, s_valid in 1, s_ready out 1; input byte stream.
REQ-010 Ports m_data out DATA_W, m_valid out 1, m_ready in 1; output byte stream.
REQ-011 Ports ram_address out ADDR_W, ram_data out DATA_W, ram_read out 1, ram_write out 1; drive RAM address/data/read_signal/write_signal.
REQ-012 Port ram_dataout  in  DATA_W  RAM registered read data.
REQ-013 Ports busy out 1 (transfer in progress), done out 1 (one-cycle completion pulse).

Function
REQ-014 States IDLE, LOAD, RD, CAP, OUT, FIN; state, cur_addr (ADDR_W), remaining (LEN_W) and m_data are registers.
REQ-015 cmd_ready = 1 only in IDLE; busy = 1 in every state except IDLE.
REQ-016 IDLE, command accepted: cur_addr <= cmd_base, remaining <= cmd_len; next state FIN if cmd_len = 0, else LOAD (cmd_dir = 0) or RD (cmd_dir = 1).
REQ-017 LOAD: s_ready = 1; ram_write = s_valid; ram_data = s_data and ram_address = cur_addr, combinationally in the same cycle (RAM writes on the falling edge).
REQ-018 LOAD, s_valid high at a rising edge: cur_addr +1, remaining -1; at remaining = 1, next state FIN.
REQ-019 LOAD, s_valid low: no write, no counter change, stay in LOAD (stall indefinitely).
REQ-020 RD: ram_read = 1, ram_address = cur_addr; next state CAP unconditionally.
REQ-021 CAP: ram_read = 0; m_data <= ram_dataout at rising edge; next state OUT.
REQ-022 OUT: m_valid = 1, m_data held stable until m_ready; on m_valid & m_ready: cur_addr +1, remaining -1, next state FIN if remaining = 1, else RD.
REQ-023 DUMP throughput: at most 1 byte per 3 cycles; LOAD throughput: 1 byte per cycle.
REQ-024 cur_addr increments modulo 2^ADDR_W (0xFFFF wraps to 0x0000); no range check against RAM depth.
REQ-025 FIN: done = 1 for exactly one cycle, busy = 1; next state IDLE.
REQ-026 ram_read and ram_write are never high in the same cycle; both low in IDLE, CAP, OUT, FIN.
REQ-027 s_ready = 0 and m_valid = 0 outside LOAD and OUT respectively; cmd_valid outside IDLE is ignored.
REQ-028 ram_address = cur_addr in all states; ram_data = s_data in all states (qualified only by ram_write).

Reset
REQ-029 RST high: state IDLE, cur_addr 0, remaining 0, m_data 0 immediately, without waiting for a clock edge.
REQ-030 Reset outputs: cmd_ready 1, busy 0, done 0, s_ready 0, m_valid 0, ram_read 0, ram_write 0, ram_address 0.
REQ-031 RST asserted mid-transfer abandons the transfer; no done pulse; bytes already written remain in RAM.

Verification
REQ-032 LOAD base 0x0100 len 4, bytes 0xA1..0xA4 on consecutive cycles -> RAM[0x0100..0x0103] = A1..A4, done pulse 1 cycle after 4th byte, busy low next cycle.
REQ-033 DUMP base 0x0100 len 4 after REQ-032, m_ready held 1 -> m_data sequence A1,A2,A3,A4, 3 cycles per byte, single done pulse.
REQ-034 LOAD len 3 with s_valid low 2 cycles between bytes -> exactly 3 writes, ram_write low in stall cycles, addresses unchanged while stalled.
REQ-035 DUMP len 2 with m_ready low 5 cycles on first byte -> m_valid and m_data stable throughout stall, no extra ram_read.
REQ-036 LOAD base 0xFFFF len 2, bytes 0x11,0x22 -> writes at 0xFFFF then 0x0000.
REQ-037 cmd_len 0 -> done 1 cycle after acceptance, no ram_read/ram_write; RST during DUMP byte 2 -> all outputs at reset values immediately, no done.

Source files
------------

// File: rtl/ram_stream_dma.sv
// Byte-stream <-> RAM mover: LOAD writes an input stream into RAM one byte per
// cycle, DUMP reads RAM through a registered-read port and streams it out.
module ram_stream_dma #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_read,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_dataout,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RD   = 3'd2,
    ST_CAP  = 3'd3,
    ST_OUT  = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ZERO = '0;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      m_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      m_data_q    <= m_data_d;
    end
  end

  // Next state and datapath updates; address arithmetic wraps naturally.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    m_data_d    = m_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cur_addr_d  = cmd_base;
          remaining_d = cmd_len;
          if (cmd_len == LEN_ZERO) state_d = ST_FIN;
          else if (cmd_dir)        state_d = ST_RD;
          else                     state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (s_valid) begin
          cur_addr_d  = cur_addr_q + ADDR_ONE;
          remaining_d = remaining_q - LEN_ONE;
          if (remaining_q == LEN_ONE) state_d = ST_FIN;
        end
      end
      ST_RD: begin
        state_d = ST_CAP;
      end
      ST_CAP: begin
        m_data_d = ram_dataout;
        state_d  = ST_OUT;
      end
      ST_OUT: begin
        if (m_ready) begin
          cur_addr_d  = cur_addr_q + ADDR_ONE;
          remaining_d = remaining_q - LEN_ONE;
          state_d     = (remaining_q == LEN_ONE) ? ST_FIN : ST_RD;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    ram_read  = 1'b0;
    ram_write = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_LOAD: begin
        s_ready   = 1'b1;
        ram_write = s_valid;
      end
      ST_RD:   ram_read = 1'b1;
      ST_CAP:  ;
      ST_OUT:  m_valid = 1'b1;
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  assign ram_address = cur_addr_q;
  assign ram_data    = s_data;
  assign m_data      = m_data_q;

endmodule

// File: tb/tb_ram_stream_dma.sv
// Directed bench: a table of LOAD/DUMP transfers against a behavioural RAM,
// plus hand sequences for zero-length commands and reset during a DUMP.
module tb_ram_stream_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_dir;
  logic [15:0] cmd_base, cmd_len;
  logic [7:0]  s_data;
  logic        s_valid, s_ready;
  logic [7:0]  m_data;
  logic        m_valid, m_ready;
  logic [15:0] ram_address;
  logic [7:0]  ram_data;
  logic        ram_read, ram_write;
  logic [7:0]  ram_dataout;
  logic        busy, done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_stream_dma #(.ADDR_W(16), .DATA_W(8), .LEN_W(16)) dut (
    .clk(clk), .RST(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .ram_address(ram_address), .ram_data(ram_data),
    .ram_read(ram_read), .ram_write(ram_write), .ram_dataout(ram_dataout),
    .busy(busy), .done(done)
  );

  // Behavioural RAM: writes on the falling edge, registered read on the rising edge.
  logic [7:0] mem [0:65535];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (ram_write) begin
      mem[ram_address] <= ram_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (ram_read) begin
      ram_dataout <= mem[ram_address];
      rd_cnt <= rd_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    bit              dir;
    logic [15:0]     base;
    logic [15:0]     len;
    int              gap;
    logic [3:0][7:0] d;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input bit dir, input logic [15:0] base, input logic [15:0] len);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_base  = base;
    cmd_len   = len;
    #1;
    chk("accept_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic finish_check(input string tag, input int done0);
    #1;
    chk({tag, "_fin_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_fin_busy"}, {31'd0, busy}, 32'd1);
    tick();
    chk({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, "_done_pulses"}, done_cnt - done0, 32'd1);
  endtask

  task automatic run_load(input int vi);
    vec_t v = vecs[vi];
    int w0 = wr_cnt;
    int d0 = done_cnt;
    logic [15:0] a;
    string tag = $sformatf("v%0d_load", vi);
    accept(1'b0, v.base, v.len);
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.base + 16'(i);
      if (i > 0) begin
        for (int g = 0; g < v.gap; g++) begin
          s_valid = 1'b0;
          #1;
          chk($sformatf("%s_stall%0d_%0d_wr", tag, i, g), {31'd0, ram_write}, 32'd0);
          chk($sformatf("%s_stall%0d_%0d_addr", tag, i, g), {16'd0, ram_address}, {16'd0, a});
          chk($sformatf("%s_stall%0d_%0d_sready", tag, i, g), {31'd0, s_ready}, 32'd1);
          tick();
        end
      end
      s_valid = 1'b1;
      s_data  = v.d[i];
      #1;
      chk($sformatf("%s_b%0d_wr", tag, i), {30'd0, ram_write, ram_read}, 32'd2);
      chk($sformatf("%s_b%0d_addr", tag, i), {16'd0, ram_address}, {16'd0, a});
      chk($sformatf("%s_b%0d_data", tag, i), {24'd0, ram_data}, {24'd0, v.d[i]});
      tick();
    end
    s_valid = 1'b0;
    finish_check(tag, d0);
    chk({tag, "_writes"}, wr_cnt - w0, 32'(v.len));
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.base + 16'(i);
      chk($sformatf("%s_mem%0d", tag, i), {24'd0, mem[a]}, {24'd0, v.d[i]});
    end
  endtask

  task automatic run_dump(input int vi);
    vec_t v = vecs[vi];
    int r0 = rd_cnt;
    int d0 = done_cnt;
    logic [15:0] a;
    string tag = $sformatf("v%0d_dump", vi);
    accept(1'b1, v.base, v.len);
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.base + 16'(i);
      #1;
      chk($sformatf("%s_b%0d_rd", tag, i), {30'd0, ram_write, ram_read}, 32'd1);
      chk($sformatf("%s_b%0d_rdaddr", tag, i), {16'd0, ram_address}, {16'd0, a});
      chk($sformatf("%s_b%0d_rd_mvalid", tag, i), {31'd0, m_valid}, 32'd0);
      tick();
      chk($sformatf("%s_b%0d_cap", tag, i), {30'd0, m_valid, ram_read}, 32'd0);
      m_ready = (i == 0 && v.gap > 0) ? 1'b0 : 1'b1;
      tick();
      for (int g = 0; g < ((i == 0) ? v.gap : 0); g++) begin
        cmd_valid = 1'b1;
        cmd_base  = 16'h1234;
        #1;
        chk($sformatf("%s_stall%0d_mvalid", tag, g), {31'd0, m_valid}, 32'd1);
        chk($sformatf("%s_stall%0d_mdata", tag, g), {24'd0, m_data}, {24'd0, v.d[i]});
        chk($sformatf("%s_stall%0d_rd", tag, g), {31'd0, ram_read}, 32'd0);
        chk($sformatf("%s_stall%0d_cmdrdy", tag, g), {31'd0, cmd_ready}, 32'd0);
        chk($sformatf("%s_stall%0d_addr", tag, g), {16'd0, ram_address}, {16'd0, a});
        tick();
      end
      cmd_valid = 1'b0;
      m_ready   = 1'b1;
      #1;
      chk($sformatf("%s_b%0d_mvalid", tag, i), {31'd0, m_valid}, 32'd1);
      chk($sformatf("%s_b%0d_mdata", tag, i), {24'd0, m_data}, {24'd0, v.d[i]});
      tick();
    end
    finish_check(tag, d0);
    chk({tag, "_reads"}, rd_cnt - r0, 32'(v.len));
  endtask

  initial begin
    int w0, r0, d0;
    vecs[0] = '{dir: 1'b0, base: 16'h0100, len: 16'd4, gap: 0, d: {8'hA4, 8'hA3, 8'hA2, 8'hA1}};
    vecs[1] = '{dir: 1'b1, base: 16'h0100, len: 16'd4, gap: 0, d: {8'hA4, 8'hA3, 8'hA2, 8'hA1}};
    vecs[2] = '{dir: 1'b0, base: 16'h0200, len: 16'd3, gap: 2, d: {8'h00, 8'hB3, 8'hB2, 8'hB1}};
    vecs[3] = '{dir: 1'b1, base: 16'h0200, len: 16'd2, gap: 5, d: {8'h00, 8'h00, 8'hB2, 8'hB1}};
    vecs[4] = '{dir: 1'b0, base: 16'hFFFF, len: 16'd2, gap: 0, d: {8'h00, 8'h00, 8'h22, 8'h11}};
    vecs[5] = '{dir: 1'b1, base: 16'hFFFF, len: 16'd2, gap: 0, d: {8'h00, 8'h00, 8'h22, 8'h11}};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_base = '0; cmd_len = '0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
    #3;
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_ctrl", {26'd0, busy, done, s_ready, m_valid, ram_read, ram_write}, 32'd0);
    chk("reset_addr", {16'd0, ram_address}, 32'd0);
    chk("reset_mdata", {24'd0, m_data}, 32'd0);
    #14;
    rst = 1'b0;
    tick();

    for (int vi = 0; vi < 6; vi++) begin
      if (vecs[vi].dir) run_dump(vi);
      else              run_load(vi);
    end

    // Zero-length command: straight to the completion pulse, no RAM traffic.
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
    accept(1'b1, 16'h0300, 16'd0);
    #1;
    chk("len0_rw", {30'd0, ram_read, ram_write}, 32'd0);
    finish_check("len0", d0);
    chk("len0_traffic", (wr_cnt - w0) + (rd_cnt - r0), 32'd0);

    // Reset while byte 2 of a DUMP is being read.
    d0 = done_cnt;
    accept(1'b1, 16'h0100, 16'd4);
    tick();
    tick();
    tick();
    #1;
    chk("rstmid_pre_rd", {31'd0, ram_read}, 32'd1);
    chk("rstmid_pre_addr", {16'd0, ram_address}, 32'h0101);
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rstmid_ctrl", {26'd0, busy, done, s_ready, m_valid, ram_read, ram_write}, 32'd0);
    chk("rstmid_addr", {16'd0, ram_address}, 32'd0);
    chk("rstmid_mdata", {24'd0, m_data}, 32'd0);
    #2;
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("rstmid_no_done", done_cnt - d0, 32'd0);
    chk("rstmid_idle", {30'd0, busy, cmd_ready}, 32'd1);
    chk("rstmid_mem_kept", {24'd0, mem[16'h0101]}, 32'hA2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
